// File: rtl/rot_dma_sched.sv
// rot_dma_sched: AHB master sequencer for the rotation engine DMA port.
// Round-robin between source-fetch reads and pixel-store writes, fixed INCR bursts.
module rot_dma_sched #(
  parameter int BURST_LEN = 4,
  parameter int BEAT_W    = 3
) (
  input  logic        I_HCLK,
  input  logic        I_HRESET_N,
  input  logic        I_RD_REQ,
  input  logic [31:0] I_RD_ADDR,
  output logic        O_RD_ACK,
  output logic        O_RD_VALID,
  output logic [31:0] O_RD_DATA,
  input  logic        I_WR_REQ,
  input  logic [31:0] I_WR_ADDR,
  input  logic [31:0] I_WR_DATA,
  output logic        O_WR_POP,
  output logic        O_WR_ACK,
  output logic        O_BUSY,
  output logic        O_DMA_HBUSREQ,
  input  logic        I_DMA_HGRANT,
  input  logic        I_DMA_HREADY,
  input  logic [31:0] I_DMA_HRDATA,
  output logic [31:0] O_DMA_HADDR,
  output logic [1:0]  O_DMA_HTRANS,
  output logic        O_DMA_HWRITE,
  output logic [2:0]  O_DMA_HSIZE,
  output logic [3:0]  O_DMA_HBURST,
  output logic [31:0] O_DMA_HWDATA
);

  localparam int ALIGN = (BURST_LEN == 8) ? 5 : 4;
  localparam logic [31:0] AMASK = ~((32'd1 << ALIGN) - 32'd1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [3:0] HBURST = (BURST_LEN == 8) ? 4'd5 : 4'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_BURST, S_LAST
  } state_e;

  state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [BEAT_W-1:0] acnt_q, acnt_d;
  logic [BEAT_W-1:0] dcnt_q, dcnt_d;
  logic wr_q, wr_d;
  logic last_wr_q, last_wr_d;
  logic rvalid_q, rvalid_d;
  logic rack_q, rack_d;
  logic wack_q, wack_d;
  logic pick_wr, aphase, acc, dbeat;

  assign aphase  = (state_q == S_ADDR) || (state_q == S_BURST);
  assign acc     = aphase && I_DMA_HREADY;
  assign dbeat   = I_DMA_HREADY &&
                   ((state_q == S_BURST) || (state_q == S_LAST));
  assign pick_wr = I_WR_REQ && (!I_RD_REQ || !last_wr_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    hwdata_d  = hwdata_q;
    rdata_d   = rdata_q;
    acnt_d    = acnt_q;
    dcnt_d    = dcnt_q;
    wr_d      = wr_q;
    last_wr_d = last_wr_q;
    rvalid_d  = 1'b0;
    rack_d    = 1'b0;
    wack_d    = 1'b0;
    if (dbeat) begin
      dcnt_d = dcnt_q + 1'b1;
      if (!wr_q) begin
        rvalid_d = 1'b1;
        rdata_d  = I_DMA_HRDATA;
      end
    end
    if (acc) begin
      addr_d = addr_q + 32'd4;
      acnt_d = acnt_q + 1'b1;
      if (wr_q) hwdata_d = I_WR_DATA;
    end
    unique case (state_q)
      S_IDLE: begin
        // the cycle carrying an ack is the mandatory gap between bursts
        if ((I_RD_REQ || I_WR_REQ) && !rack_q && !wack_q) begin
          state_d = S_REQ;
          wr_d    = pick_wr;
          addr_d  = (pick_wr ? I_WR_ADDR : I_RD_ADDR) & AMASK;
          acnt_d  = '0;
          dcnt_d  = '0;
        end
      end
      S_REQ: if (I_DMA_HGRANT && I_DMA_HREADY) state_d = S_ADDR;
      S_ADDR: if (I_DMA_HREADY) state_d = S_BURST;
      S_BURST: begin
        if (I_DMA_HREADY && acnt_q == LAST_BEAT) state_d = S_LAST;
      end
      S_LAST: begin
        if (I_DMA_HREADY && dcnt_q == LAST_BEAT) begin
          state_d   = S_IDLE;
          last_wr_d = wr_q;
          rack_d    = !wr_q;
          wack_d    = wr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
    if (!I_HRESET_N) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      hwdata_q  <= '0;
      rdata_q   <= '0;
      acnt_q    <= '0;
      dcnt_q    <= '0;
      wr_q      <= 1'b0;
      last_wr_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rack_q    <= 1'b0;
      wack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      hwdata_q  <= hwdata_d;
      rdata_q   <= rdata_d;
      acnt_q    <= acnt_d;
      dcnt_q    <= dcnt_d;
      wr_q      <= wr_d;
      last_wr_q <= last_wr_d;
      rvalid_q  <= rvalid_d;
      rack_q    <= rack_d;
      wack_q    <= wack_d;
    end
  end

  assign O_BUSY        = state_q != S_IDLE;
  assign O_DMA_HBUSREQ = (state_q == S_REQ) || aphase;
  assign O_DMA_HTRANS  = (state_q == S_ADDR)  ? 2'b10 :
                         (state_q == S_BURST) ? 2'b11 : 2'b00;
  assign O_DMA_HADDR   = aphase ? addr_q : 32'd0;
  assign O_DMA_HWRITE  = aphase && wr_q;
  assign O_DMA_HBURST  = aphase ? HBURST : 4'd0;
  assign O_DMA_HSIZE   = 3'b010;
  assign O_DMA_HWDATA  = hwdata_q;
  assign O_WR_POP      = acc && wr_q;
  assign O_RD_VALID    = rvalid_q;
  assign O_RD_DATA     = rdata_q;
  assign O_RD_ACK      = rack_q;
  assign O_WR_ACK      = wack_q;

endmodule

// File: tb/tb_rot_dma_sched.sv
// tb_rot_dma_sched: randomized bench with an AHB slave, requesters
// and a burst-level reference model for rot_dma_sched.
module tb_rot_dma_sched;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd_req = 0, wr_req = 0;
  logic [31:0] rd_addr = 0, wr_addr = 0, wr_data = 0;
  logic hgrant = 0, hready = 0;
  logic [31:0] hrdata = 0;
  logic rd_ack, rd_valid, wr_pop, wr_ack, busy, busreq, hwrite;
  logic [31:0] rd_data, haddr, hwdata;
  logic [1:0] htrans;
  logic [2:0] hsize;
  logic [3:0] hburst;

  rot_dma_sched #(.BURST_LEN(BL), .BEAT_W(3)) dut (
    .I_HCLK(clk), .I_HRESET_N(rst_n),
    .I_RD_REQ(rd_req), .I_RD_ADDR(rd_addr),
    .O_RD_ACK(rd_ack), .O_RD_VALID(rd_valid), .O_RD_DATA(rd_data),
    .I_WR_REQ(wr_req), .I_WR_ADDR(wr_addr), .I_WR_DATA(wr_data),
    .O_WR_POP(wr_pop), .O_WR_ACK(wr_ack), .O_BUSY(busy),
    .O_DMA_HBUSREQ(busreq), .I_DMA_HGRANT(hgrant),
    .I_DMA_HREADY(hready), .I_DMA_HRDATA(hrdata),
    .O_DMA_HADDR(haddr), .O_DMA_HTRANS(htrans),
    .O_DMA_HWRITE(hwrite), .O_DMA_HSIZE(hsize),
    .O_DMA_HBURST(hburst), .O_DMA_HWDATA(hwdata)
  );

  always #5 clk = ~clk;

  wire [108:0] outs_all = {busreq, htrans, haddr, hwrite, hburst, hwdata,
                           busy, rd_ack, wr_ack, rd_valid, rd_data, wr_pop};

  int tests = 0, fails = 0, cyc = 0;
  int ready_mode = 0, grant_delay = 0, gcnt = 0, stall_left = 0;
  logic [31:0] wfifo[$];
  bit pop_pend = 0, rd_drop = 0, wr_drop = 0;
  bit rd_ok = 1, wr_ok = 1, rd_req_p = 0, wr_req_p = 0;
  logic [31:0] addr_q[$], rd_exp[$], rd_obs[$], wd_obs[$];
  logic [1:0] trans_q[$];
  logic [7:0] ctl_q[$];
  int order_q[$];
  int valid_cnt, pop_cnt, rack_cnt, wack_cnt, stall_cnt, stall_viol;
  int beats_done, last_beat_cyc, ack_cyc, grant_cyc, nonseq_cyc, gidle_cnt;
  bit pend = 0, pend_wr = 0, prev_stall = 0;
  logic [66:0] prev_hold;
  int mdl_last;

  // AHB slave, requester housekeeping and monitor
  always @(negedge clk) begin
    cyc++;
    if (pop_pend && wfifo.size() > 0) void'(wfifo.pop_front());
    pop_pend = 0;
    if (rd_drop) rd_req = 0;
    if (wr_drop) wr_req = 0;
    rd_drop = 0;
    wr_drop = 0;
    if (ready_mode == 0) hready = 1;
    else if (ready_mode == 1) hready = ($urandom_range(0, 3) != 0);
    else if (beats_done == 1 && stall_left > 0) begin
      hready = 0;
      stall_left--;
    end else hready = 1;
    if (busreq) begin
      hgrant = (gcnt >= grant_delay);
      gcnt++;
    end else begin
      hgrant = 0;
      gcnt = 0;
    end
    hrdata = $urandom();
    wr_data = (wfifo.size() > 0) ? wfifo[0] : 32'd0;
    #1;
    if (!rst_n) begin
      pend = 0;
      prev_stall = 0;
    end else begin
      if (pend && hready) begin
        if (pend_wr) wd_obs.push_back(hwdata);
        else rd_exp.push_back(hrdata);
        beats_done++;
        pend = 0;
        if (beats_done == BL) last_beat_cyc = cyc;
      end
      if (htrans[1] && hready) begin
        if (htrans == 2'b10) beats_done = 0;
        addr_q.push_back(haddr);
        trans_q.push_back(htrans);
        ctl_q.push_back({hwrite, hsize, hburst});
        pend = 1;
        pend_wr = hwrite;
      end
      if (rd_valid) begin valid_cnt++; rd_obs.push_back(rd_data); end
      if (wr_pop) begin pop_cnt++; pop_pend = 1; end
      if (rd_req && !rd_req_p) rd_ok = 0;
      if (wr_req && !wr_req_p) wr_ok = 0;
      if (rd_ack) begin
        rack_cnt++; ack_cyc = cyc; order_q.push_back(0);
        rd_drop = 1; rd_ok = 1;
      end
      if (wr_ack) begin
        wack_cnt++; ack_cyc = cyc; order_q.push_back(1);
        wr_drop = 1; wr_ok = 1;
      end
      if (busy && !hready) stall_cnt++;
      if (prev_stall && busy && {haddr, htrans, hwdata, hwrite} != prev_hold)
        stall_viol++;
      prev_stall = busy && !hready;
      prev_hold = {haddr, htrans, hwdata, hwrite};
      if (busreq && !hgrant && busy && htrans == 2'b00) gidle_cnt++;
      if (busreq && hgrant && hready && htrans == 2'b00) grant_cyc = cyc;
      if (htrans == 2'b10 && nonseq_cyc < 0) nonseq_cyc = cyc;
    end
    if (rd_req_p && !rd_req)
      assert (rd_ok) else $error("FAIL req_drop rd before ack");
    if (wr_req_p && !wr_req)
      assert (wr_ok) else $error("FAIL req_drop wr before ack");
    rd_req_p = rd_req;
    wr_req_p = wr_req;
  end

  task automatic clear_rec();
    addr_q.delete(); rd_exp.delete(); rd_obs.delete(); wd_obs.delete();
    trans_q.delete(); ctl_q.delete(); order_q.delete();
    valid_cnt = 0; pop_cnt = 0; rack_cnt = 0; wack_cnt = 0;
    stall_cnt = 0; stall_viol = 0; beats_done = 0; gidle_cnt = 0;
    last_beat_cyc = -10; ack_cyc = -20; grant_cyc = -10; nonseq_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rd_ok = 1; wr_ok = 1;
    rst_n = 0; rd_req = 0; wr_req = 0;
    wfifo.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    mdl_last = 1;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (!rd_req && !wr_req && !busy && !rd_ack && !wr_ack) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #3;
    rst_n = 0;
    #1;
    tests++;
    if (outs_all !== '0) begin
      fails++; $display("FAIL reset_outs: got %h required 0", outs_all);
    end
    tests++;
    if (hsize !== 3'b010) begin
      fails++; $display("FAIL reset_hsize: got %b required 010", hsize);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    mdl_last = 1;
    clear_rec();
    repeat (3) @(negedge clk);
    #2;
    tests++;
    if (busy !== 1'b0 || busreq !== 1'b0) begin
      fails++; $display("FAIL reset_idle: busy=%b busreq=%b required 0 0", busy, busreq);
    end
  endtask

  task automatic test_single_read();
    bit ok;
    logic [31:0] a;
    clear_rec();
    ready_mode = 0; grant_delay = 2;
    rd_addr = 32'h1000; rd_req = 1;
    wait_idle(200, ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL rd_timeout: got %b required 1", ok); end
    tests++;
    if (addr_q.size() != BL) begin
      fails++; $display("FAIL rd_nbeats: got %0d required %0d", addr_q.size(), BL);
    end
    for (int i = 0; i < BL; i++) begin
      a = (i < addr_q.size()) ? addr_q[i] : 32'hDEAD0001;
      tests++;
      if (a !== 32'h1000 + 32'(4 * i)) begin
        fails++; $display("FAIL rd_haddr[%0d]: got %h required %h", i, a, 32'h1000 + 32'(4 * i));
      end
      tests++;
      if (i < trans_q.size() && trans_q[i] !== ((i == 0) ? 2'b10 : 2'b11)) begin
        fails++; $display("FAIL rd_htrans[%0d]: got %b", i, trans_q[i]);
      end
      tests++;
      if (i < ctl_q.size() && ctl_q[i] !== 8'h23) begin
        fails++; $display("FAIL rd_ctl[%0d]: got %h required 23", i, ctl_q[i]);
      end
    end
    tests++;
    if (valid_cnt != BL) begin
      fails++; $display("FAIL rd_valids: got %0d required %0d", valid_cnt, BL);
    end
    for (int i = 0; i < rd_exp.size(); i++) begin
      a = (i < rd_obs.size()) ? rd_obs[i] : ~rd_exp[i];
      tests++;
      if (a !== rd_exp[i]) begin
        fails++; $display("FAIL rd_data[%0d]: got %h required %h", i, a, rd_exp[i]);
      end
    end
    tests++;
    if (rack_cnt != 1 || wack_cnt != 0) begin
      fails++; $display("FAIL rd_acks: got rd=%0d wr=%0d required 1 0", rack_cnt, wack_cnt);
    end
    tests++;
    if (ack_cyc != last_beat_cyc + 1) begin
      fails++; $display("FAIL rd_ack_time: got %0d required %0d", ack_cyc, last_beat_cyc + 1);
    end
    tests++;
    if (gidle_cnt != 2 || nonseq_cyc != grant_cyc + 1) begin
      fails++; $display("FAIL rd_grant: got wait=%0d start=%0d required 2 %0d", gidle_cnt, nonseq_cyc, grant_cyc + 1);
    end
    mdl_last = 0;
  endtask

  task automatic test_single_write();
    bit ok;
    logic [31:0] a;
    clear_rec();
    ready_mode = 0; grant_delay = 1;
    for (int i = 0; i < BL; i++) wfifo.push_back(32'hA0 + 32'(i));
    wr_addr = 32'h2000; wr_req = 1;
    wait_idle(200, ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL wr_timeout: got %b required 1", ok); end
    for (int i = 0; i < BL; i++) begin
      a = (i < addr_q.size()) ? addr_q[i] : 32'hDEAD0002;
      tests++;
      if (a !== 32'h2000 + 32'(4 * i)) begin
        fails++; $display("FAIL wr_haddr[%0d]: got %h required %h", i, a, 32'h2000 + 32'(4 * i));
      end
      tests++;
      if (i < ctl_q.size() && ctl_q[i] !== 8'hA3) begin
        fails++; $display("FAIL wr_ctl[%0d]: got %h required a3", i, ctl_q[i]);
      end
      a = (i < wd_obs.size()) ? wd_obs[i] : 32'hDEAD0003;
      tests++;
      if (a !== 32'hA0 + 32'(i)) begin
        fails++; $display("FAIL wr_hwdata[%0d]: got %h required %h", i, a, 32'hA0 + 32'(i));
      end
    end
    tests++;
    if (pop_cnt != BL || wack_cnt != 1 || rack_cnt != 0) begin
      fails++; $display("FAIL wr_counts: got pop=%0d wack=%0d rack=%0d required %0d 1 0", pop_cnt, wack_cnt, rack_cnt, BL);
    end
    mdl_last = 1;
  endtask

  // served order and address/data streams from the arbitration rules
  task automatic test_round_robin();
    bit ok;
    int exp_order[$];
    logic [31:0] exp_addr[$], exp_wd[$], a, w;
    do_reset();
    clear_rec();
    ready_mode = 1; grant_delay = $urandom_range(0, 3);
    for (int r = 0; r < 2; r++) begin
      rd_addr = $urandom() & 32'hFFFF_FFF0;
      wr_addr = $urandom() & 32'hFFFF_FFF0;
      for (int i = 0; i < BL; i++) begin
        w = $urandom(); wfifo.push_back(w); exp_wd.push_back(w);
      end
      for (int k = 0; k < 2; k++) begin
        int ch = (k == 0) ? 1 - mdl_last : mdl_last;
        exp_order.push_back(ch);
        for (int i = 0; i < BL; i++)
          exp_addr.push_back((ch == 1 ? wr_addr : rd_addr) + 32'(4 * i));
      end
      mdl_last = exp_order[exp_order.size() - 1];
      rd_req = 1; wr_req = 1;
      wait_idle(400, ok);
      tests++;
      if (ok !== 1'b1) begin fails++; $display("FAIL rr_timeout[%0d]: got %b required 1", r, ok); end
    end
    for (int i = 0; i < exp_order.size(); i++) begin
      tests++;
      if (i >= order_q.size() || order_q[i] != exp_order[i]) begin
        fails++; $display("FAIL rr_order[%0d]: got %0d required %0d", i, (i < order_q.size()) ? order_q[i] : -1, exp_order[i]);
      end
    end
    for (int i = 0; i < exp_addr.size(); i++) begin
      a = (i < addr_q.size()) ? addr_q[i] : ~exp_addr[i];
      tests++;
      if (a !== exp_addr[i]) begin
        fails++; $display("FAIL rr_haddr[%0d]: got %h required %h", i, a, exp_addr[i]);
      end
    end
    for (int i = 0; i < exp_wd.size(); i++) begin
      a = (i < wd_obs.size()) ? wd_obs[i] : ~exp_wd[i];
      tests++;
      if (a !== exp_wd[i]) begin
        fails++; $display("FAIL rr_hwdata[%0d]: got %h required %h", i, a, exp_wd[i]);
      end
    end
    tests++;
    if (rd_obs.size() != 2 * BL || rd_obs != rd_exp) begin
      fails++; $display("FAIL rr_rdata: got %0d beats required %0d matching", rd_obs.size(), 2 * BL);
    end
  endtask

  task automatic test_wait_states();
    bit ok;
    for (int ch = 0; ch < 2; ch++) begin
      clear_rec();
      ready_mode = 2; stall_left = 3; grant_delay = 0;
      if (ch == 1) begin
        for (int i = 0; i < BL; i++) wfifo.push_back(32'hC0 + 32'(i));
        wr_addr = 32'h3000; wr_req = 1;
      end else begin
        rd_addr = 32'h4000; rd_req = 1;
      end
      wait_idle(200, ok);
      mdl_last = ch;
      tests++;
      if (ok !== 1'b1) begin fails++; $display("FAIL ws_timeout[%0d]: got %b required 1", ch, ok); end
      tests++;
      if (stall_cnt != 3 || stall_viol != 0) begin
        fails++; $display("FAIL ws_stall[%0d]: got stalls=%0d moved=%0d required 3 0", ch, stall_cnt, stall_viol);
      end
      tests++;
      if (addr_q.size() != BL || beats_done != BL) begin
        fails++; $display("FAIL ws_beats[%0d]: got %0d/%0d required %0d", ch, addr_q.size(), beats_done, BL);
      end
      tests++;
      if ((ch == 0 ? valid_cnt : pop_cnt) != BL) begin
        fails++; $display("FAIL ws_pulses[%0d]: got %0d required %0d", ch, ch == 0 ? valid_cnt : pop_cnt, BL);
      end
      tests++;
      if (ch == 0 ? rd_obs != rd_exp : wd_obs.size() != BL || wd_obs[2] !== 32'hC2) begin
        fails++; $display("FAIL ws_data[%0d]: got %0d beats required %0d matching", ch, ch == 0 ? rd_obs.size() : wd_obs.size(), BL);
      end
    end
  endtask

  task automatic test_delayed_grant();
    bit ok;
    clear_rec();
    ready_mode = 0; grant_delay = 10;
    rd_addr = 32'h5000; rd_req = 1;
    wait_idle(200, ok);
    mdl_last = 0;
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL dg_timeout: got %b required 1", ok); end
    tests++;
    if (gidle_cnt != 10) begin
      fails++; $display("FAIL dg_wait: got %0d required 10", gidle_cnt);
    end
    tests++;
    if (nonseq_cyc != grant_cyc + 1) begin
      fails++; $display("FAIL dg_start: got %0d required %0d", nonseq_cyc, grant_cyc + 1);
    end
    tests++;
    if (rack_cnt != 1 || valid_cnt != BL) begin
      fails++; $display("FAIL dg_done: got ack=%0d valid=%0d required 1 %0d", rack_cnt, valid_cnt, BL);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_rec();
    ready_mode = 0; grant_delay = 0;
    rd_addr = 32'h6000; rd_req = 1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (beats_done >= 2) begin ok = 1; break; end
    end
    @(posedge clk); #2;
    rd_ok = 1; rd_req = 0; rst_n = 0;
    #1;
    tests++;
    if (ok !== 1'b1 || outs_all !== '0 || hsize !== 3'b010) begin
      fails++; $display("FAIL rm_outs: got reached=%b outs=%h required 1 0", ok, outs_all);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (rack_cnt != 0 || wack_cnt != 0) begin
      fails++; $display("FAIL rm_noack: got %0d %0d required 0 0", rack_cnt, wack_cnt);
    end
    #2 rst_n = 1;
    mdl_last = 1;
    clear_rec();
    for (int i = 0; i < BL; i++) wfifo.push_back(32'hE0 + 32'(i));
    wr_addr = 32'h7008; wr_req = 1;
    wait_idle(200, ok);
    mdl_last = 1;
    tests++;
    if (ok !== 1'b1 || wack_cnt != 1) begin
      fails++; $display("FAIL rm_after: got idle=%b ack=%0d required 1 1", ok, wack_cnt);
    end
    tests++;
    if (addr_q.size() != BL || addr_q[0] !== 32'h7000 || wd_obs.size() != BL || wd_obs[3] !== 32'hE3) begin
      fails++; $display("FAIL rm_burst: got %0d beats first=%h required %0d 7000", addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 32'hx, BL);
    end
  endtask

  task automatic test_random();
    bit ok;
    int exp_order[$], sel;
    logic [31:0] exp_addr[$], exp_wd[$], a;
    do_reset();
    for (int it = 0; it < 8; it++) begin
      clear_rec();
      exp_order.delete(); exp_addr.delete(); exp_wd.delete();
      ready_mode = 1; grant_delay = $urandom_range(0, 4);
      sel = $urandom_range(1, 3);
      rd_addr = $urandom(); wr_addr = $urandom();
      if (sel == 3) begin
        exp_order.push_back(1 - mdl_last); exp_order.push_back(mdl_last);
      end else exp_order.push_back(sel - 1);
      mdl_last = exp_order[exp_order.size() - 1];
      foreach (exp_order[k])
        for (int i = 0; i < BL; i++)
          exp_addr.push_back(((exp_order[k] == 1 ? wr_addr : rd_addr) & 32'hFFFF_FFF0) + 32'(4 * i));
      if (sel[1]) for (int i = 0; i < BL; i++) begin
        a = $urandom(); wfifo.push_back(a); exp_wd.push_back(a);
      end
      rd_req = sel[0]; wr_req = sel[1];
      wait_idle(400, ok);
      tests++;
      if (ok !== 1'b1) begin fails++; $display("FAIL rnd_timeout[%0d]: got %b required 1", it, ok); end
      tests++;
      if (order_q != exp_order) begin
        fails++; $display("FAIL rnd_order[%0d]: got %0d acks required %0d", it, order_q.size(), exp_order.size());
      end
      for (int i = 0; i < exp_addr.size(); i++) begin
        a = (i < addr_q.size()) ? addr_q[i] : ~exp_addr[i];
        tests++;
        if (a !== exp_addr[i] || (i < trans_q.size() && trans_q[i] !== ((i % BL == 0) ? 2'b10 : 2'b11))) begin
          fails++; $display("FAIL rnd_addr[%0d.%0d]: got %h required %h", it, i, a, exp_addr[i]);
        end
      end
      tests++;
      if (wd_obs != exp_wd || rd_obs != rd_exp || stall_viol != 0) begin
        fails++; $display("FAIL rnd_data[%0d]: got wr=%0d rd=%0d moved=%0d", it, wd_obs.size(), rd_obs.size(), stall_viol);
      end
    end
  endtask

  initial begin
    clear_rec();
    prev_hold = '0;
    mdl_last = 1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_wait_states();
    test_delayed_grant();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
